// File: rtl/avr_pkg.sv
// Shared AVR data-bus widths, default SRAM base and debug-port FSM states
// for the data-space responder.
package avr_pkg;

  localparam int AVR_DADDR_W = 16;
  localparam int AVR_DATA_W  = 8;

  localparam logic [AVR_DADDR_W-1:0] AVR_SRAM_BASE = 16'h0060;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_WAIT,
    WR_DONE,
    ACK
  } dbg_state_e;

endpackage

// File: rtl/avr_sram_1w2r.sv
// Byte SRAM with one write port and two registered read ports; a read of the
// address being written in the same cycle returns the new data.
module avr_sram_1w2r
  import avr_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [AVR_DATA_W-1:0] wdata,
  input  logic [AW-1:0]         raddr_a,
  output logic [AVR_DATA_W-1:0] rdata_a,
  input  logic [AW-1:0]         raddr_b,
  output logic [AVR_DATA_W-1:0] rdata_b
);

  logic [AVR_DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_a <= (we && (waddr == raddr_a)) ? wdata : mem[raddr_a];
    rdata_b <= (we && (waddr == raddr_b)) ? wdata : mem[raddr_b];
  end

endmodule

// File: rtl/avr_data_mem.sv
// AVR data-space responder: core bus with 1-cycle read latency, handshaked
// debug port sharing the single SRAM write port. Optional: AVR_DMEM_WATERMARK_EN.
module avr_data_mem
  import avr_pkg::*;
#(
  parameter int                     DEPTH = 512,
  parameter logic [AVR_DADDR_W-1:0] BASE  = AVR_SRAM_BASE
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [AVR_DADDR_W-1:0] cpu_addr,
  input  logic [AVR_DATA_W-1:0]  cpu_wdata,
  input  logic                   cpu_we,
  output logic [AVR_DATA_W-1:0]  cpu_rdata,
  input  logic                   dbg_req,
  input  logic                   dbg_we,
  input  logic [AVR_DADDR_W-1:0] dbg_addr,
  input  logic [AVR_DATA_W-1:0]  dbg_wdata,
  output logic                   dbg_ack,
  output logic [AVR_DATA_W-1:0]  dbg_rdata,
  input  logic                   dbg_clr_err,
  output logic                   oob_err,
  output logic [AVR_DADDR_W-1:0] stack_low
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LIMIT = int'(BASE) + DEPTH;

  function automatic logic in_range(input logic [AVR_DADDR_W-1:0] a);
    return (int'(a) >= int'(BASE)) && (int'(a) < LIMIT);
  endfunction

  function automatic logic above_range(input logic [AVR_DADDR_W-1:0] a);
    return int'(a) >= LIMIT;
  endfunction

  function automatic logic [AW-1:0] to_index(input logic [AVR_DADDR_W-1:0] a);
    logic [AVR_DADDR_W-1:0] off;
    off = a - BASE;
    return off[AW-1:0];
  endfunction

  dbg_state_e state, state_next;

  logic                  cpu_hit, dbg_hit;
  logic                  core_wr, dbg_fire, dbg_wr;
  logic                  mem_we;
  logic [AW-1:0]         mem_waddr;
  logic [AVR_DATA_W-1:0] mem_wdata;
  logic [AVR_DATA_W-1:0] sram_a, sram_b;
  logic                  cpu_hit_p1;
  logic                  oob_set;

  assign cpu_hit = in_range(cpu_addr);
  assign dbg_hit = in_range(dbg_addr);

  // Stage p0: decode and write-port arbitration (core always wins)
  assign core_wr   = cpu_we && cpu_hit;
  assign dbg_wr    = dbg_fire && dbg_hit && RST_N;
  assign mem_we    = core_wr || dbg_wr;
  assign mem_waddr = core_wr ? to_index(cpu_addr) : to_index(dbg_addr);
  assign mem_wdata = core_wr ? cpu_wdata : dbg_wdata;

  // Low-space reads are I/O decode, so only reads past the top flag an error.
  assign oob_set = cpu_we ? !cpu_hit : above_range(cpu_addr);

  avr_sram_1w2r #(
    .DEPTH (DEPTH)
  ) u_sram (
    .clk     (CLK),
    .we      (mem_we),
    .waddr   (mem_waddr),
    .wdata   (mem_wdata),
    .raddr_a (to_index(cpu_addr)),
    .rdata_a (sram_a),
    .raddr_b (to_index(dbg_addr)),
    .rdata_b (sram_b)
  );

  // Stage p1: core read data, forced to zero for out-of-range addresses
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cpu_hit_p1 <= 1'b0;
    end else begin
      cpu_hit_p1 <= cpu_hit;
    end
  end

  assign cpu_rdata = cpu_hit_p1 ? sram_a : '0;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      oob_err <= 1'b0;
    end else if (oob_set) begin
      oob_err <= 1'b1;
    end else if (dbg_clr_err) begin
      oob_err <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    dbg_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (dbg_req) begin
          if (!dbg_we) begin
            state_next = RD;
          end else if (!cpu_we) begin
            dbg_fire   = 1'b1;
            state_next = WR_DONE;
          end else begin
            state_next = WR_WAIT;
          end
        end
      end
      WR_WAIT: begin
        if (!cpu_we) begin
          dbg_fire   = 1'b1;
          state_next = WR_DONE;
        end
      end
      RD:      state_next = ACK;
      WR_DONE: state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign dbg_ack = (state == ACK);

  // Port b captured the debug address on entry to RD; latch it for the ack.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      dbg_rdata <= '0;
    end else if (state == RD) begin
      dbg_rdata <= dbg_hit ? sram_b : '0;
    end
  end

`ifdef AVR_DMEM_WATERMARK_EN
  logic [AVR_DADDR_W-1:0] low_mark;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      low_mark <= 16'hFFFF;
    end else if (core_wr && (cpu_addr < low_mark)) begin
      low_mark <= cpu_addr;
    end
  end

  assign stack_low = low_mark;
`else
  assign stack_low = 16'hFFFF;
`endif

endmodule

// File: tb/tb_avr_data_mem.sv
// Bench for avr_data_mem: directed scenarios plus random core traffic checked
// against an address-keyed byte model.
module tb_avr_data_mem;

  localparam int TB_BASE  = 16'h0060;
  localparam int TB_DEPTH = 512;
  localparam int TB_LIMIT = TB_BASE + TB_DEPTH;

  logic        CLK;
  logic        RST_N;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic [7:0]  cpu_rdata;
  logic        dbg_req;
  logic        dbg_we;
  logic [15:0] dbg_addr;
  logic [7:0]  dbg_wdata;
  logic        dbg_ack;
  logic [7:0]  dbg_rdata;
  logic        dbg_clr_err;
  logic        oob_err;
  logic [15:0] stack_low;

  avr_data_mem #(
    .DEPTH (TB_DEPTH),
    .BASE  (16'h0060)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_we      (cpu_we),
    .cpu_rdata   (cpu_rdata),
    .dbg_req     (dbg_req),
    .dbg_we      (dbg_we),
    .dbg_addr    (dbg_addr),
    .dbg_wdata   (dbg_wdata),
    .dbg_ack     (dbg_ack),
    .dbg_rdata   (dbg_rdata),
    .dbg_clr_err (dbg_clr_err),
    .oob_err     (oob_err),
    .stack_low   (stack_low)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0]  mem_m [int];
  logic        oob_m = 1'b0;
  logic [15:0] wm    = 16'hFFFF;

  function automatic logic [15:0] exp_stack_low();
`ifdef AVR_DMEM_WATERMARK_EN
    return wm;
`else
    return 16'hFFFF;
`endif
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One core-bus cycle: drive, predict, clock, compare.
  task automatic step(input logic [15:0] a, input logic w, input logic [7:0] d,
                      input logic ack_exp);
    int         ai;
    logic       inr;
    logic       known;
    logic [7:0] exp_rd;
    cpu_addr  = a;
    cpu_we    = w;
    cpu_wdata = d;
    ai  = int'(a);
    inr = (ai >= TB_BASE) && (ai < TB_LIMIT);
    known  = 1'b1;
    exp_rd = 8'h00;
    if (inr) begin
      if (w) exp_rd = d;
      else if (mem_m.exists(ai)) exp_rd = mem_m[ai];
      else known = 1'b0;
    end
    if (w && inr) begin
      mem_m[ai] = d;
      if (a < wm) wm = a;
    end
    if (w ? !inr : (ai >= TB_LIMIT)) oob_m = 1'b1;
    else if (dbg_clr_err) oob_m = 1'b0;
    @(posedge CLK);
    #1;
    if (known) check("cpu_rdata", {8'h00, cpu_rdata}, {8'h00, exp_rd});
    check("oob_err", {15'h0, oob_err}, {15'h0, oob_m});
    check("dbg_ack", {15'h0, dbg_ack}, {15'h0, ack_exp});
    check("stack_low", stack_low, exp_stack_low());
  endtask

  initial begin
    RST_N       = 1'b0;
    cpu_addr    = 16'h0000;
    cpu_wdata   = 8'h00;
    cpu_we      = 1'b0;
    dbg_req     = 1'b0;
    dbg_we      = 1'b0;
    dbg_addr    = 16'h0000;
    dbg_wdata   = 8'h00;
    dbg_clr_err = 1'b0;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("rst_cpu_rdata", {8'h00, cpu_rdata}, 16'h0000);
    check("rst_dbg_ack", {15'h0, dbg_ack}, 16'h0000);
    check("rst_dbg_rdata", {8'h00, dbg_rdata}, 16'h0000);
    check("rst_oob_err", {15'h0, oob_err}, 16'h0000);
    check("rst_stack_low", stack_low, 16'hFFFF);
    RST_N = 1'b1;

    // Watermark: last write is out of range and does not move it
    step(16'h025F, 1'b1, 8'h01, 1'b0);
    step(16'h025E, 1'b1, 8'h02, 1'b0);
    step(16'h0260, 1'b1, 8'h03, 1'b0);
`ifdef AVR_DMEM_WATERMARK_EN
    check("wm_low", stack_low, 16'h025E);
`else
    check("wm_tied", stack_low, 16'hFFFF);
`endif
    dbg_clr_err = 1'b1;
    step(16'h0000, 1'b0, 8'h00, 1'b0);
    dbg_clr_err = 1'b0;

    // Write then read back; same-cycle write-first
    step(16'h0100, 1'b1, 8'h5A, 1'b0);
    step(16'h0100, 1'b0, 8'h00, 1'b0);
    check("rd_0100", {8'h00, cpu_rdata}, 16'h005A);
    step(16'h0080, 1'b1, 8'hC3, 1'b0);
    check("wf_0080", {8'h00, cpu_rdata}, 16'h00C3);

    // Out-of-range reads, clear, set-over-clear priority
    step(16'h0300, 1'b0, 8'h00, 1'b0);
    check("oob_hi_rd", {8'h00, cpu_rdata}, 16'h0000);
    check("oob_hi_flag", {15'h0, oob_err}, 16'h0001);
    dbg_clr_err = 1'b1;
    step(16'h0100, 1'b0, 8'h00, 1'b0);
    dbg_clr_err = 1'b0;
    check("oob_clr", {15'h0, oob_err}, 16'h0000);
    step(16'h003F, 1'b0, 8'h00, 1'b0);
    check("lo_no_flag", {15'h0, oob_err}, 16'h0000);
    dbg_clr_err = 1'b1;
    step(16'h0400, 1'b0, 8'h00, 1'b0);
    check("set_over_clr", {15'h0, oob_err}, 16'h0001);
    step(16'h0080, 1'b0, 8'h00, 1'b0);
    dbg_clr_err = 1'b0;

    // Debug write held off by two core-write cycles
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0090; dbg_wdata = 8'h77;
    step(16'h0200, 1'b1, 8'h11, 1'b0);
    step(16'h0201, 1'b1, 8'h22, 1'b0);
    mem_m[16'h0090] = 8'h77;
    step(16'h0090, 1'b0, 8'h00, 1'b0);
    check("dbgwr_wf", {8'h00, cpu_rdata}, 16'h0077);
    step(16'h0090, 1'b0, 8'h00, 1'b1);
    dbg_req = 1'b0;
    step(16'h0090, 1'b0, 8'h00, 1'b0);
    check("dbgwr_rd", {8'h00, cpu_rdata}, 16'h0077);

    // Debug write with the port free lands on the request edge
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h00A0; dbg_wdata = 8'h3C;
    mem_m[16'h00A0] = 8'h3C;
    step(16'h00A0, 1'b0, 8'h00, 1'b0);
    step(16'h00A0, 1'b0, 8'h00, 1'b1);
    dbg_req = 1'b0;
    step(16'h00A0, 1'b0, 8'h00, 1'b0);

    // Debug out-of-range write: acked, no flag
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0400; dbg_wdata = 8'hEE;
    step(16'h0100, 1'b0, 8'h00, 1'b0);
    step(16'h0100, 1'b0, 8'h00, 1'b1);
    dbg_req = 1'b0;
    step(16'h0100, 1'b0, 8'h00, 1'b0);

    // Debug read: ack on the third cycle of the request
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0100;
    step(16'h0080, 1'b0, 8'h00, 1'b0);
    step(16'h0080, 1'b0, 8'h00, 1'b1);
    check("dbg_rdata", {8'h00, dbg_rdata}, 16'h005A);
    dbg_req = 1'b0;
    step(16'h0080, 1'b0, 8'h00, 1'b0);
    check("dbg_rdata_hold", {8'h00, dbg_rdata}, 16'h005A);

    // Reset while in RD: no ack, read data cleared
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0100;
    step(16'h0080, 1'b0, 8'h00, 1'b0);
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    check("mid_rst_ack", {15'h0, dbg_ack}, 16'h0000);
    check("mid_rst_rdata", {8'h00, dbg_rdata}, 16'h0000);
    check("mid_rst_cpu", {8'h00, cpu_rdata}, 16'h0000);
    dbg_req = 1'b0;
    @(posedge CLK);
    #1;
    check("mid_rst_ack2", {15'h0, dbg_ack}, 16'h0000);
    RST_N = 1'b1;
    oob_m = 1'b0;
    wm    = 16'hFFFF;
    step(16'h0080, 1'b0, 8'h00, 1'b0);
    step(16'h0080, 1'b0, 8'h00, 1'b0);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0080;
    step(16'h0090, 1'b0, 8'h00, 1'b0);
    step(16'h0090, 1'b0, 8'h00, 1'b1);
    check("post_rst_rdata", {8'h00, dbg_rdata}, 16'h00C3);
    dbg_req = 1'b0;
    step(16'h0090, 1'b0, 8'h00, 1'b0);

    // Random core traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [15:0] ra;
      logic        rw;
      logic [7:0]  rd;
      case ($urandom % 4)
        0:       ra = 16'($urandom_range(0, 16'hFFFF));
        1:       ra = 16'($urandom_range(16'h0250, 16'h0268));
        default: ra = 16'($urandom_range(16'h0058, 16'h0078));
      endcase
      rw = 1'($urandom % 2);
      rd = 8'($urandom);
      dbg_clr_err = (($urandom % 8) == 0);
      step(ra, rw, rd, 1'b0);
    end
    dbg_clr_err = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
